// File: rtl/ac_transmitter.sv
// ac_transmitter: pulse-distance IR frame generator for the AC remote link.
// A frame is a leader mark, one space/mark pair per payload bit (the space
// width carries the bit value, LSB first), and a trailing gap. The envelope
// is exposed on ir_mark. ir_out is the same envelope gated by a 38 kHz
// carrier that restarts in phase at the start of every mark.
module ac_transmitter #(
    parameter int LEAD_MARK      = 300000,
    parameter int BIT_MARK       = 28000,
    parameter int ZERO_SPACE     = 28000,
    parameter int ONE_SPACE      = 84000,
    parameter int GAP            = 160000,
    parameter int CARRIER_PERIOD = 1316,
    parameter int CARRIER_HIGH   = 658
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] data_in,
    input  logic [7:0]   data_len,
    output logic         busy,
    output logic         done,
    output logic         ir_mark,
    output logic         ir_out
);

    localparam int CNT_W = 20;

    // Segment counters count down from length-1 to 0, so each segment
    // occupies exactly its parameter count of cycles.
    localparam logic [CNT_W-1:0] LEAD_LOAD  = CNT_W'(LEAD_MARK - 1);
    localparam logic [CNT_W-1:0] MARK_LOAD  = CNT_W'(BIT_MARK - 1);
    localparam logic [CNT_W-1:0] ZERO_LOAD  = CNT_W'(ZERO_SPACE - 1);
    localparam logic [CNT_W-1:0] ONE_LOAD   = CNT_W'(ONE_SPACE - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP - 1);
    localparam logic [10:0]      CAR_LAST   = 11'(CARRIER_PERIOD - 1);
    localparam logic [10:0]      CAR_HIGH   = 11'(CARRIER_HIGH);
    localparam logic             CAR_FIRST  = (CAR_HIGH != 11'd0);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SPACE,
        MARK,
        GAP_ST
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   dur_cnt;
    logic [6:0]         bit_idx;
    logic [7:0]         len;
    logic [127:0]       data_reg;
    logic [10:0]        car_cnt;

    logic [6:0]         next_idx;
    logic               last_bit;
    logic [10:0]        car_next;
    logic               car_next_high;
    logic [7:0]         len_clamped;
    logic [CNT_W-1:0]   first_space_load;
    logic [CNT_W-1:0]   next_space_load;

    // Space width for a given bit value.
    function automatic logic [CNT_W-1:0] space_load(input logic b);
        return b ? ONE_LOAD : ZERO_LOAD;
    endfunction

    // Next-step helpers for the sequencer: bit bookkeeping, carrier phase
    // and the clamped frame length.
    always_comb begin
        next_idx         = bit_idx + 7'd1;
        last_bit         = ({1'b0, bit_idx} == (len - 8'd1));
        car_next         = (car_cnt == CAR_LAST) ? 11'd0 : car_cnt + 11'd1;
        car_next_high    = (car_next < CAR_HIGH);
        len_clamped      = (data_len > 8'd128) ? 8'd128 : data_len;
        first_space_load = space_load(data_reg[bit_idx]);
        next_space_load  = space_load(data_reg[next_idx]);
    end

    // Frame sequencer with all outputs registered; ir_out is computed from
    // the carrier phase the counter will hold in the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dur_cnt  <= '0;
            bit_idx  <= '0;
            len      <= '0;
            data_reg <= '0;
            car_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ir_mark  <= 1'b0;
            ir_out   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (data_len != 8'd0)) begin
                        data_reg <= data_in;
                        len      <= len_clamped;
                        bit_idx  <= '0;
                        dur_cnt  <= LEAD_LOAD;
                        car_cnt  <= '0;
                        state    <= LEAD;
                        busy     <= 1'b1;
                        ir_mark  <= 1'b1;
                        ir_out   <= CAR_FIRST;
                    end
                end

                LEAD: begin
                    if (dur_cnt == '0) begin
                        state   <= SPACE;
                        dur_cnt <= first_space_load;
                        car_cnt <= '0;
                        ir_mark <= 1'b0;
                        ir_out  <= 1'b0;
                    end else begin
                        dur_cnt <= dur_cnt - 1'b1;
                        car_cnt <= car_next;
                        ir_out  <= car_next_high;
                    end
                end

                SPACE: begin
                    if (dur_cnt == '0) begin
                        state   <= MARK;
                        dur_cnt <= MARK_LOAD;
                        car_cnt <= '0;
                        ir_mark <= 1'b1;
                        ir_out  <= CAR_FIRST;
                    end else begin
                        dur_cnt <= dur_cnt - 1'b1;
                    end
                end

                MARK: begin
                    if (dur_cnt == '0) begin
                        car_cnt <= '0;
                        ir_mark <= 1'b0;
                        ir_out  <= 1'b0;
                        if (last_bit) begin
                            state   <= GAP_ST;
                            dur_cnt <= GAP_LOAD;
                            done    <= (GAP_LOAD == '0);
                        end else begin
                            state   <= SPACE;
                            bit_idx <= next_idx;
                            dur_cnt <= next_space_load;
                        end
                    end else begin
                        dur_cnt <= dur_cnt - 1'b1;
                        car_cnt <= car_next;
                        ir_out  <= car_next_high;
                    end
                end

                GAP_ST: begin
                    if (dur_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        dur_cnt <= dur_cnt - 1'b1;
                        done    <= (dur_cnt == CNT_W'(1));
                    end
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    ir_mark <= 1'b0;
                    ir_out  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ac_transmitter.md
# ac_transmitter

Pulse-distance IR frame generator for the AC remote link; the transmit counterpart of the IR frame receiver. Accepts a payload of up to 128 bits with a length and emits a leader mark, then per-bit space/mark pairs whose space width encodes the bit value, then an inter-frame gap. It drives the IR LED with a 38 kHz modulated carrier and exposes the unmodulated envelope for loopback into the receiver path. All timing is in 50 MHz clock cycles (20 ns).

## Interface
- LEAD_MARK, 300000, leader mark length in cycles (6 ms; must exceed the receiver's 230000 leader threshold)
- BIT_MARK, 28000, mark length after every bit (560 us)
- ZERO_SPACE, 28000, space length for logical 0 (must be in [20000, 40000))
- ONE_SPACE, 84000, space length for logical 1 (must be ≥ 40000 and < 150000)
- GAP, 160000, trailing space before the frame completes (must be ≥ 150000)
- CARRIER_PERIOD, 1316, carrier period in cycles (≈38 kHz)
- CARRIER_HIGH, 658, carrier high cycles per period
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  frame request, sampled each cycle
- data_in  input  128  payload; bit 0 is transmitted first
- data_len  input  8  number of bits to send, 1..128
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse on frame completion
- ir_mark  output  1  envelope: 1 = mark (carrier on), 0 = space
- ir_out  output  1  LED drive: carrier gated by ir_mark

## Operation
- States: IDLE, LEAD, SPACE, MARK, GAP. Duration counter ≥ 20 bits, bit index 7 bits, carrier counter 11 bits.
- IDLE: start=1 with data_len≠0 latches data_in and len = min(data_len,128), clears bit index, enters LEAD. start with data_len=0 is ignored. start in any other state is ignored; latched data is not modified mid-frame.
- LEAD: ir_mark=1 for LEAD_MARK cycles, then SPACE.
- SPACE: ir_mark=0 for ONE_SPACE if latched bit[idx]=1, else ZERO_SPACE, then MARK.
- MARK: ir_mark=1 for BIT_MARK cycles. At end: if idx = len−1 go to GAP, else idx+1 and go to SPACE.
- GAP: ir_mark=0 for GAP cycles; in the final GAP cycle done=1; next state IDLE.
- busy=1 in every state except IDLE.
- Carrier: counter restarts at 0 on every entry into LEAD or MARK, wraps at CARRIER_PERIOD−1. ir_out = ir_mark AND (counter < CARRIER_HIGH). ir_out=0 whenever ir_mark=0.
- Reset (asynchronous, any time including mid-frame): state IDLE; busy, done, ir_mark and ir_out all 0; counters and bit index 0; frame aborted, no done.

## Timing
- All outputs registered. start sampled high at edge T: busy and ir_mark rise at T+1.
- Frame length F = LEAD_MARK + Σ(space_i + BIT_MARK) + GAP. busy is high for cycles T+1..T+F, done is high in cycle T+F only, busy is low from T+F+1.
- Earliest next accepted start is sampled at T+F+1.
- Each segment lasts exactly its parameter count in cycles, with no extra cycles at transitions.
- The first ir_out cycle of each mark is high (carrier phase 0).

## Test plan
- len=1, data_in[0]=1, start at T → ir_mark high T+1..T+300000, low for 84000 cycles, high for 28000, low for 160000. done at T+572000; busy low at T+572001.
- len=8, data_in=0xA5 → space widths in order 84000, 28000, 84000, 28000, 28000, 84000, 28000, 84000, each followed by a 28000 mark. F = 300000 + 4·84000 + 4·28000 + 8·28000 + 160000.
- Apply data_len=0 → no activity, busy stays 0. Apply data_len=200 → exactly 128 bits sent. Assert start during a frame → ignored; the frame completes unchanged and there is only one done pulse.
- Assert rst_n low midway through SPACE of bit 5 → all outputs 0 immediately, no done. After release, a new start sends a full frame.
- Check carrier during any mark: ir_out has period 1316, 658 high / 658 low, starts high at the first mark cycle, and is 0 throughout every space.
- Loopback: drive the receiver with ~ir_mark, len=32, data_in=0xDEADBEEF → the receiver's recovered payload bits [31:0] = 0xDEADBEEF.
